psum_acc: RTL and testbench

// - Sits directly downstream of the MAC-array FSM/datapath. Consumes its psum stream (vld/rdy + 14-bit info + lane data).
// - Each output pixel arrives in two passes, one per input-channel group.
//   - Pass 0 (info[12]=0): stored in an internal psum buffer.
//   - Pass 1 (info[12]=1): added to the stored value and the final sum is emitted downstream.
// - Tracks completed output maps and channels.
// - Raises map_done for each completed output map and layer_done after the last output channel.

---
 rtl/psum_acc_if.sv | 28 ++
 rtl/psum_acc.sv | 119 +++++++++++
 tb/tb_psum_acc.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_acc_if.sv
// Stream bundle between the MAC-array psum producer, psum_acc and its downstream consumer.
// The slave modport is the accumulator's view; master is the surrounding environment.
interface psum_acc_if #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned PSUM_W = 24
);
  logic                         in_vld;
  logic                         in_rdy;
  logic [13:0]                  in_info;
  logic [LANES*PSUM_W-1:0]      in_data;
  logic                         out_vld;
  logic                         out_rdy;
  logic [LANES*(PSUM_W+1)-1:0]  out_data;
  logic [11:0]                  out_addr;
  logic                         out_half;
  logic                         map_done;
  logic                         layer_done;

  modport slave (
    input  in_vld, in_info, in_data, out_rdy,
    output in_rdy, out_vld, out_data, out_addr, out_half, map_done, layer_done
  );

  modport master (
    output in_vld, in_info, in_data, out_rdy,
    input  in_rdy, out_vld, out_data, out_addr, out_half, map_done, layer_done
  );
endinterface

// File: rtl/psum_acc.sv
// Two-pass partial-sum accumulator: pass 0 parks lane psums in a pixel buffer, pass 1 adds the
// stored value and emits the widened final sum; counts finished maps and flags layer end.
module psum_acc #(
  parameter int unsigned LANES    = 8,
  parameter int unsigned PSUM_W   = 24,
  parameter int unsigned MAP_SIZE = 3136,
  parameter int unsigned OUT_MAPS = 64
) (
  input logic       clk,
  input logic       rst_n,
  psum_acc_if.slave bus
);
  localparam int unsigned DW       = LANES * PSUM_W;
  localparam int unsigned OW       = LANES * (PSUM_W + 1);
  localparam logic [11:0] LAST_PIX = 12'(MAP_SIZE - 1);
  localparam logic [6:0]  LAST_MAP = 7'(OUT_MAPS - 1);

  logic [DW-1:0] mem [MAP_SIZE];
  logic [DW-1:0] rd_q;

  logic          s1_vld_q;
  logic          s1_p1_q;
  logic          s1_half_q;
  logic [11:0]   s1_addr_q;
  logic [DW-1:0] s1_data_q;

  logic          out_vld_q;
  logic [OW-1:0] out_data_q;
  logic [11:0]   out_addr_q;
  logic          out_half_q;
  logic          map_done_q;
  logic          layer_done_q;
  logic [6:0]    map_cnt_q;

  logic [11:0]   offset;
  logic          in_range;
  logic          accept;
  logic          s1_adv;
  logic          s1_fire;
  logic          last_hs;
  logic [OW-1:0] sum;

  assign offset   = bus.in_info[11:0];
  assign in_range = 32'(offset) < MAP_SIZE;
  // Pass-0 beats never wait on the output stage; only pass-1 beats need a free output slot.
  assign s1_adv   = s1_p1_q ? (!out_vld_q || bus.out_rdy) : 1'b1;
  assign s1_fire  = s1_vld_q && s1_p1_q && s1_adv;
  assign bus.in_rdy = rst_n && (!s1_vld_q || s1_adv);
  assign accept   = bus.in_vld && bus.in_rdy;
  assign last_hs  = out_vld_q && bus.out_rdy && (out_addr_q == LAST_PIX);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [PSUM_W-1:0] a;
    logic [PSUM_W-1:0] b;
    assign a = s1_data_q[g*PSUM_W +: PSUM_W];
    assign b = rd_q[g*PSUM_W +: PSUM_W];
    assign sum[g*(PSUM_W+1) +: PSUM_W+1] = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
  end

  // Buffer is never reset; rd_q only changes when a pass-1 read is issued, so stalls keep it.
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      if (!bus.in_info[12]) begin
        mem[offset] <= bus.in_data;
      end else begin
        rd_q <= mem[offset];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q     <= 1'b0;
      s1_p1_q      <= 1'b0;
      s1_half_q    <= 1'b0;
      s1_addr_q    <= '0;
      s1_data_q    <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
      out_half_q   <= 1'b0;
      map_done_q   <= 1'b0;
      layer_done_q <= 1'b0;
      map_cnt_q    <= '0;
    end else begin
      if (accept) begin
        s1_vld_q  <= 1'b1;
        s1_p1_q   <= bus.in_info[12];
        s1_half_q <= bus.in_info[13];
        s1_addr_q <= offset;
        s1_data_q <= bus.in_data;
      end else if (s1_adv) begin
        s1_vld_q  <= 1'b0;
      end

      if (s1_fire) begin
        out_vld_q  <= 1'b1;
        out_data_q <= sum;
        out_addr_q <= s1_addr_q;
        out_half_q <= s1_half_q;
      end else if (bus.out_rdy) begin
        out_vld_q  <= 1'b0;
      end

      map_done_q   <= last_hs;
      layer_done_q <= last_hs && (map_cnt_q == LAST_MAP);
      if (last_hs) begin
        map_cnt_q <= (map_cnt_q == LAST_MAP) ? '0 : map_cnt_q + 7'd1;
      end
    end
  end

  assign bus.out_vld    = out_vld_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_half   = out_half_q;
  assign bus.map_done   = map_done_q;
  assign bus.layer_done = layer_done_q;
endmodule

// File: tb/tb_psum_acc.sv
// Bench for psum_acc: directed pixel/width/backpressure/reset/map/layer cases plus random traffic,
// all scored against a lane-arithmetic reference of the two-pass accumulation.
module tb_psum_acc;
  localparam int LANES = 8;
  localparam int PW    = 24;
  localparam int OWL   = PW + 1;
  localparam int MS    = 3136;
  localparam int NMAPS = 64;

  logic clk;
  logic rst_n;
  psum_acc_if #(.LANES(LANES), .PSUM_W(PW)) bus ();

  psum_acc #(.LANES(LANES), .PSUM_W(PW), .MAP_SIZE(MS), .OUT_MAPS(NMAPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*OWL-1:0] data;
    logic [11:0]          addr;
    logic                 half;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int md_seen = 0;
  int ld_seen = 0;
  int hs_cnt = 0;
  int rdy_mode = 0;
  exp_t exp_q[$];
  logic [LANES*PW-1:0] mem_m [MS];
  int  maps_m = 0;
  bit  md_exp = 1'b0;
  bit  ld_exp = 1'b0;

  task automatic check(input string name, input logic [LANES*OWL-1:0] act,
                       input logic [LANES*OWL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Reference: the output stream is, in acceptance order, the lane-wise signed sum of each
  // pass-1 beat with whatever pass-0 data was last stored for that pixel.
  always @(negedge clk) begin : cmp
    exp_t e;
    int   s;
    int   off;
    bit   md_nxt;
    bit   ld_nxt;
    check("map_done", 200'(bus.map_done), 200'(md_exp));
    check("layer_done", 200'(bus.layer_done), 200'(ld_exp));
    if (bus.map_done === 1'b1) md_seen++;
    if (bus.layer_done === 1'b1) ld_seen++;
    md_nxt = 1'b0;
    ld_nxt = 1'b0;
    if (bus.out_vld !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_vld act=%b exp=0", bus.out_vld);
      end else begin
        check("out_data", bus.out_data, exp_q[0].data);
        check("out_addr", 200'(bus.out_addr), 200'(exp_q[0].addr));
        check("out_half", 200'(bus.out_half), 200'(exp_q[0].half));
      end
    end
    if (!rst_n) begin
      check("in_rdy_in_reset", 200'(bus.in_rdy), 200'd0);
      exp_q.delete();
      maps_m = 0;
    end else begin
      if (bus.out_vld === 1'b1 && bus.out_rdy && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        hs_cnt++;
        if (int'(e.addr) == MS - 1) begin
          maps_m++;
          md_nxt = 1'b1;
          if (maps_m == NMAPS) begin
            ld_nxt = 1'b1;
            maps_m = 0;
          end
        end
      end
      if (bus.in_vld && bus.in_rdy === 1'b1) begin
        off = int'(bus.in_info[11:0]);
        if (!bus.in_info[12]) begin
          if (off < MS) mem_m[off] = bus.in_data;
        end else begin
          e.data = '0;
          for (int i = 0; i < LANES; i++) begin
            s = int'($signed(bus.in_data[i*PW +: PW])) + int'($signed(mem_m[off][i*PW +: PW]));
            e.data[i*OWL +: OWL] = OWL'(s);
          end
          e.addr = bus.in_info[11:0];
          e.half = bus.in_info[13];
          exp_q.push_back(e);
        end
      end
    end
    md_exp = md_nxt;
    ld_exp = ld_nxt;
  end

  initial begin
    bus.out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_rdy = 1'b1;
        1:       bus.out_rdy = ($urandom_range(0, 3) != 0);
        default: bus.out_rdy = 1'b0;
      endcase
    end
  end

  task automatic send(input bit p1, input bit half, input int off, input logic [LANES*PW-1:0] d);
    bit acc;
    int n;
    bus.in_vld  = 1'b1;
    bus.in_info = {half, p1, 12'(off)};
    bus.in_data = d;
    acc = 1'b0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = (bus.in_rdy === 1'b1);
      @(posedge clk);
      #1;
      if (!acc) begin
        stalls++;
        n++;
        if (n > 1000) begin
          checks++;
          errors++;
          $display("FAIL send_timeout act=stalled exp=accepted off=%0d", off);
          finish_now();
        end
      end
    end
    bus.in_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d pending exp=0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*PW-1:0] rnd_data();
    logic [LANES*PW-1:0] d;
    for (int i = 0; i < LANES * PW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [LANES*PW-1:0]  d;
    logic [LANES*PW-1:0]  d2;
    logic [LANES*OWL-1:0] x;
    int md0;
    int ld0;
    int hs0;
    int st0;
    rst_n       = 1'b0;
    bus.in_vld  = 1'b0;
    bus.in_info = '0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_vld", 200'(bus.out_vld), 200'd0);
    check("rst_out_data", bus.out_data, 200'd0);
    check("rst_out_addr", 200'(bus.out_addr), 200'd0);
    check("rst_out_half", 200'(bus.out_half), 200'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_rdy_after_reset", 200'(bus.in_rdy), 200'd1);
    @(posedge clk);
    #1;

    // Single pixel: 100 + (-30) = 70 in every lane, out_vld two cycles after pass-1 accept.
    for (int i = 0; i < LANES; i++) begin
      d[i*PW +: PW]  = 24'd100;
      d2[i*PW +: PW] = 24'hFFFFE2;
      x[i*OWL +: OWL] = 25'd70;
    end
    send(1'b0, 1'b0, 5, d);
    send(1'b1, 1'b1, 5, d2);
    @(negedge clk);
    check("latency_cycle1_vld", 200'(bus.out_vld), 200'd0);
    @(negedge clk);
    check("latency_cycle2_vld", 200'(bus.out_vld), 200'd1);
    check("pixel5_data", bus.out_data, x);
    check("pixel5_addr", 200'(bus.out_addr), 200'd5);
    check("pixel5_half", 200'(bus.out_half), 200'd1);
    @(posedge clk);
    #1;

    // Width edge: max+max and min+min must widen, not wrap.
    for (int i = 0; i < LANES; i++) begin
      d[i*PW +: PW]   = (i % 2 == 0) ? 24'h7FFFFF : 24'h800000;
      x[i*OWL +: OWL] = (i % 2 == 0) ? 25'h0FFFFFE : 25'h1000000;
    end
    send(1'b0, 1'b0, 7, d);
    send(1'b1, 1'b0, 7, d);
    @(negedge clk);
    @(negedge clk);
    check("width_edge_data", bus.out_data, x);
    @(posedge clk);
    #1;
    drain();

    // Backpressure: two beats fit (output reg + S1), the third must be held off.
    for (int o = 10; o < 23; o++) send(1'b0, 1'b0, o, rnd_data());
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(1'b1, 1'b0, 20, rnd_data());
    send(1'b1, 1'b1, 21, rnd_data());
    bus.in_vld  = 1'b1;
    bus.in_info = {1'b0, 1'b1, 12'd22};
    bus.in_data = rnd_data();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_in_rdy_low", 200'(bus.in_rdy), 200'd0);
      @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    send(1'b1, 1'b0, 22, bus.in_data);
    drain();

    // Reset while a final sum is held: it must vanish the cycle after reset is sampled.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(1'b1, 1'b0, 10, rnd_data());
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_reset_out_vld", 200'(bus.out_vld), 200'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_reset_out_vld", 200'(bus.out_vld), 200'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Full map at full rate.
    md0 = md_seen;
    hs0 = hs_cnt;
    st0 = stalls;
    for (int o = 0; o < MS; o++) send(1'b0, 1'b0, o, rnd_data());
    for (int o = 0; o < MS; o++) send(1'b1, 1'b0, o, rnd_data());
    drain();
    check("full_map_stalls", 200'(stalls - st0), 200'd0);
    check("full_map_outputs", 200'(hs_cnt - hs0), 200'(MS));
    check("full_map_map_done", 200'(md_seen - md0), 200'd1);

    // Random traffic with random backpressure and gaps.
    rdy_mode = 1;
    for (int n = 0; n < 1500; n++) begin
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? MS - 1 : int'($urandom_range(0, MS - 1)), rnd_data());
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    drain();

    // Layer end: 64 last-pixel outputs after reset give 64 map_done and one layer_done.
    do_reset();
    md0 = md_seen;
    ld0 = ld_seen;
    for (int m = 0; m < NMAPS; m++) send(1'b1, 1'b0, MS - 1, rnd_data());
    drain();
    check("layer_map_done_cnt", 200'(md_seen - md0), 200'(NMAPS));
    check("layer_done_cnt", 200'(ld_seen - ld0), 200'd1);

    finish_now();
  end

  initial begin
    #2000000;
    checks++;
    errors++;
    $display("FAIL watchdog act=running exp=finished");
    finish_now();
  end
endmodule
